instr_issue_queue: RTL and testbench

//  Upstream issue stage for the ALU: buffers instruction_t words (opcode, a, b) from the decoder.

---
 rtl/definitions_pkg.sv | 17 +
 rtl/instr_issue_queue.sv | 102 ++++++++++
 tb/tb_instr_issue_queue.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/definitions_pkg.sv
// Shared instruction definitions for the decoder, issue queue and ALU.
package definitions_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        MULT = 3'd2,
        DIV  = 3'd3
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [31:0] a;
        logic [31:0] b;
    } instruction_t;

endpackage

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: FIFO between decoder and ALU with valid/ready on both sides and flush.
// Optional INSTR_QUEUE_STATS_EN adds issued_cnt/stall_cnt statistics outputs.
module instr_issue_queue
    import definitions_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  instruction_t       in_word,
    input  logic               in_valid,
    output logic               in_ready,
    output instruction_t       IW,
    output logic               iw_valid,
    input  logic               alu_ready,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
`ifdef INSTR_QUEUE_STATS_EN
    ,
    output logic [31:0]        issued_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    instruction_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign iw_valid = ~empty;
    assign IW       = empty ? '0 : mem_q[rd_ptr_q];
    assign in_ready = ~full & ~flush;

    assign push = in_valid & in_ready;
    assign pop  = iw_valid & alu_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; count gates everything visible.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_word;
    end

`ifdef INSTR_QUEUE_STATS_EN
    logic [31:0] issued_q, issued_d;
    logic [31:0] stall_q, stall_d;

    // A pop coinciding with flush is discarded, so it is not counted as issued.
    always_comb begin
        issued_d = issued_q + 32'(pop & ~flush);
        stall_d  = stall_q + 32'(iw_valid & ~alu_ready);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign issued_cnt = issued_q;
    assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed self-checking bench for instr_issue_queue (DEPTH=4).
module tb_instr_issue_queue;
    import definitions_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic         flush;
    instruction_t in_word;
    logic         in_valid;
    logic         in_ready;
    instruction_t IW;
    logic         iw_valid;
    logic         alu_ready;
    logic [2:0]   count;
    logic         full;
    logic         empty;
`ifdef INSTR_QUEUE_STATS_EN
    logic [31:0]  issued_cnt;
    logic [31:0]  stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    instr_issue_queue #(.DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .IW        (IW),
        .iw_valid  (iw_valid),
        .alu_ready (alu_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef INSTR_QUEUE_STATS_EN
        ,
        .issued_cnt(issued_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Minimal ALU stand-in: registers a+b of each word it accepts.
    logic [31:0] alu_res;
    always @(posedge clock) begin
        if (iw_valid && alu_ready) alu_res <= IW.a + IW.b;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic instruction_t mk(input opcode_t op, input logic [31:0] a, input logic [31:0] b);
        instruction_t w;
        w.opcode = op;
        w.a      = a;
        w.b      = b;
        return w;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input instruction_t w);
        in_word  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    instruction_t w[6];
    int sent, recv, mcnt;
    logic exp_push, exp_pop;

    initial begin
        reset = 1'b1; flush = 1'b0; in_word = '0; in_valid = 1'b0; alu_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        tick();

        // 1: reset / idle
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_iw_valid", iw_valid, 0);
        check("rst_iw", IW, 0);
        check("rst_in_ready", in_ready, 1);

        // 2: single word, one-cycle latency, ALU consumes it
        alu_ready = 1'b1;
        push_word(mk(ADD, 32'd5, 32'd7));
        check("lat_iw_valid", iw_valid, 1);
        check("lat_iw", IW, mk(ADD, 32'd5, 32'd7));
        check("lat_count", count, 1);
        tick();
        check("alu_result", alu_res, 32'd12);
        check("lat_empty_after", empty, 1);

        // 3: fill while stalled, overflow attempt ignored, drain in order
        alu_ready = 1'b0;
        for (int i = 0; i < 4; i++) w[i] = mk(opcode_t'(i), 32'h100 + i, 32'h200 + i);
        for (int i = 0; i < 4; i++) push_word(w[i]);
        check("fill_full", full, 1);
        check("fill_in_ready", in_ready, 0);
        check("fill_count", count, 4);
        push_word(mk(DIV, 32'hdead, 32'hbeef));
        check("ovf_count", count, 4);
        check("stall_hold_iw", IW, w[0]);
        alu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), IW, w[i]);
            tick();
        end
        check("drain_empty", empty, 1);

        // 4: full queue with in_valid & alu_ready -> only pop, then push accepted
        alu_ready = 1'b0;
        for (int i = 0; i < 4; i++) w[i] = mk(SUB, 32'h300 + i, 32'h1);
        for (int i = 0; i < 4; i++) push_word(w[i]);
        w[4] = mk(MULT, 32'h777, 32'h3);
        in_word = w[4]; in_valid = 1'b1; alu_ready = 1'b1;
        tick();
        check("fullpop_count", count, 3);
        check("fullpop_iw", IW, w[1]);
        alu_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("fullpop_push_count", count, 4);
        alu_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check($sformatf("fp_drain_%0d", i), IW, w[i]);
            tick();
        end
        check("fp_empty", empty, 1);

        // 5: flush with concurrent push
        alu_ready = 1'b0;
        push_word(mk(ADD, 32'h11, 32'h1));
        push_word(mk(ADD, 32'h22, 32'h2));
        check("pre_flush_count", count, 2);
        flush = 1'b1; in_valid = 1'b1; in_word = mk(SUB, 32'h33, 32'h3);
        #1 check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_iw_valid", iw_valid, 0);
        check("flush_iw", IW, 0);
        tick();
        check("flush_word_lost", count, 0);

        // 6: six words through with alternating stalls (pointer wrap)
        for (int i = 0; i < 6; i++) w[i] = mk(opcode_t'(i % 4), 32'h1000 * (i + 1), 32'h40 + i);
        sent = 0; recv = 0; mcnt = 0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            in_valid  = (sent < 6);
            in_word   = (sent < 6) ? w[sent] : '0;
            alu_ready = cyc[0];
            #1;
            check($sformatf("wrap_ready_c%0d", cyc), in_ready, (mcnt < 4));
            check($sformatf("wrap_count_c%0d", cyc), count, mcnt);
            exp_push = in_valid && (mcnt < 4);
            exp_pop  = alu_ready && (mcnt > 0);
            if (exp_pop) check($sformatf("wrap_iw_%0d", recv), IW, w[recv]);
            if (exp_push) sent++;
            if (exp_pop) recv++;
            mcnt = mcnt + int'(exp_push) - int'(exp_pop);
            tick();
        end
        in_valid = 1'b0;
        check("wrap_all_received", recv, 6);
        check("wrap_empty", empty, 1);

        // Reset mid-transfer discards content immediately
        alu_ready = 1'b0;
        push_word(mk(MULT, 32'h5, 32'h6));
        push_word(mk(DIV, 32'h8, 32'h2));
        #2 reset = 1'b1;
        #1 check("midrst_iw_valid", iw_valid, 0);
        check("midrst_iw", IW, 0);
        check("midrst_count", count, 0);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
